// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder.
// Holds the default operand width / array dimension and the feeder state
// encoding used by systolic_feeder.
package systolic_pkg;

    localparam int BITS_DEF = 8;
    localparam int DIM_DEF  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// skew_lane: per-lane delay line for the systolic feeder.
// A DEPTH-stage shift register that moves only when adv is high and is
// wiped by a synchronous clr. DEPTH=0 is a plain combinational pass-through.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   adv         shift enable (array advance)
//   clr         synchronous clear of all stages (wins over adv)
//   din         operand entering the lane
//   dout        operand leaving the lane, DEPTH advances later
module skew_lane #(
    parameter int DEPTH = 0,
    parameter int BITS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            adv,
    input  logic            clr,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, adv, clr};
            assign dout = din;
        end else begin : g_shift
            logic [BITS-1:0] stage_q [DEPTH];
            logic [BITS-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d = stage_q;
                if (clr) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage_d[k] = '0;
                    end
                end else if (adv) begin
                    stage_d[0] = din;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage_d[k] = stage_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage_q[k] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: accepts DIM step vectors (column k of A, row k of B) and
// presents them to a DIM x DIM output-stationary systolic array with the
// diagonal skew the array needs, then flushes the pipeline with zeros.
//
// Optional feature: define SYSTOLIC_FEEDER_ABORT_EN to add an abort input
// that cancels a job in LOAD/FLUSH (back to IDLE, skew registers cleared,
// no done pulse).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle job request (honoured only in IDLE)
//   abort              (SYSTOLIC_FEEDER_ABORT_EN only) cancel current job
//   in_valid/in_ready  step-vector handshake
//   A_col, B_row       step-k operands, lane i at [i*BITS +: BITS]
//   A_out, B_out       skewed operands to the array (zero when mac_en=0)
//   mac_en             array advance enable
//   busy               high in LOAD or FLUSH
//   done               one-cycle pulse once the array results are final
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting DIM step vectors, stalls when in_valid is low
// FLUSH | shifting zeros for 2*DIM-2 cycles to drain the skew
// DONE  | one-cycle done pulse
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int BITS = BITS_DEF,
    parameter int DIM  = DIM_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
`ifdef SYSTOLIC_FEEDER_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DIM*BITS-1:0] A_col,
    input  logic signed [DIM*BITS-1:0] B_row,
    output logic signed [DIM*BITS-1:0] A_out,
    output logic signed [DIM*BITS-1:0] B_out,
    output logic                       mac_en,
    output logic                       busy,
    output logic                       done
);

    localparam int              CW         = $clog2(2*DIM);
    localparam logic [CW-1:0]   LAST_STEP  = CW'(DIM-1);
    localparam logic [CW-1:0]   LAST_FLUSH = CW'(2*DIM-3);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                abort_w;
    logic                xfer;
    logic                lane_clr;
    logic [DIM*BITS-1:0] feed_a, feed_b;
    logic [DIM*BITS-1:0] skew_a, skew_b;

`ifdef SYSTOLIC_FEEDER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Abort beats in_valid, so an aborted LOAD cycle is never a transfer.
    assign xfer = (state_q == ST_LOAD) && in_valid && !abort_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // One counter serves both phases: step index in LOAD, flush cycle in FLUSH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort_w) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_FLUSH) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_LOAD) && !abort_w;
        busy     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
        done     = (state_q == ST_DONE);
        mac_en   = xfer || ((state_q == ST_FLUSH) && !abort_w);
        // Wipe the skew both on a fresh job and on abort so stale operands
        // can never leak into the next job.
        lane_clr = ((state_q == ST_IDLE) && start) ||
                   (abort_w && ((state_q == ST_LOAD) || (state_q == ST_FLUSH)));
    end

    // Zeros enter the lanes on every non-transfer cycle, which is what
    // drains the pipeline during FLUSH.
    assign feed_a = xfer ? A_col : '0;
    assign feed_b = xfer ? B_row : '0;

    generate
        for (genvar i = 0; i < DIM; i++) begin : g_lane
            skew_lane #(
                .DEPTH(i),
                .BITS (BITS)
            ) u_skew_a (
                .clk  (clk),
                .rst_n(rst_n),
                .adv  (mac_en),
                .clr  (lane_clr),
                .din  (feed_a[i*BITS +: BITS]),
                .dout (skew_a[i*BITS +: BITS])
            );

            skew_lane #(
                .DEPTH(i),
                .BITS (BITS)
            ) u_skew_b (
                .clk  (clk),
                .rst_n(rst_n),
                .adv  (mac_en),
                .clr  (lane_clr),
                .din  (feed_b[i*BITS +: BITS]),
                .dout (skew_b[i*BITS +: BITS])
            );
        end
    endgenerate

    assign A_out = mac_en ? skew_a : '0;
    assign B_out = mac_en ? skew_b : '0;

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter BITS, default 8, operand width in bits.
REQ-002 SHALL have parameter DIM, default 32, array dimension (lanes).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a DIM x DIM multiply.
REQ-006 SHALL have port in_valid  input  1  A_col/B_row carry step-k operands.
REQ-007 SHALL have port in_ready  output  1  feeder accepts a step vector this cycle.
REQ-008 SHALL have port A_col  input  signed BITS x DIM  column k of A, lane i = A[i][k].
REQ-009 SHALL have port B_row  input  signed BITS x DIM  row k of B, lane j = B[k][j].
REQ-010 SHALL have port A_out  output  signed BITS x DIM  skewed row inputs to the array.
REQ-011 SHALL have port B_out  output  signed BITS x DIM  skewed column inputs to the array.
REQ-012 SHALL have port mac_en  output  1  array advance enable.
REQ-013 SHALL have port busy  output  1  high in LOAD or FLUSH.
REQ-014 SHALL have port done  output  1  one-cycle pulse; array results final.

Function
REQ-015 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-016 IDLE: start -> LOAD with step counter cleared; start ignored in any other state.
REQ-017 LOAD: in_ready=1; transfer on in_valid&&in_ready; counter increments per transfer; LOAD -> FLUSH on transfer of step DIM-1.
REQ-018 LOAD with in_valid=0: mac_en=0, all skew registers and counters hold (full-pipeline stall).
REQ-019 FLUSH: in_ready=0, zeros shifted into all lanes, mac_en=1 every cycle for exactly 2*DIM-2 cycles, then -> DONE.
REQ-020 DONE: done=1, mac_en=0 for one cycle, then -> IDLE.
REQ-021 Lane i of A and lane j of B SHALL be delayed by i and j advancing cycles respectively; lane 0 combinationally passes the accepted operand (zero when not transferring).
REQ-022 mac_en SHALL be high on every transfer cycle and every FLUSH cycle; total mac_en cycles per job exactly 3*DIM-2.
REQ-023 A_out/B_out SHALL be zero whenever mac_en=0.
REQ-024 Counter width SHALL be $clog2(2*DIM) bits; no wrap in normal operation.
REQ-025 Operands SHALL pass unmodified (no arithmetic, no sign change).

Reset
REQ-026 rst_n low SHALL force state IDLE, counters 0, all skew registers 0, in_ready=0, mac_en=0, busy=0, done=0, A_out/B_out=0.
REQ-027 Reset mid-job SHALL discard the job; no done pulse follows.

Configuration
REQ-028 With SYSTOLIC_FEEDER_ABORT_EN defined: extra input abort (1 bit); abort in LOAD/FLUSH -> IDLE next cycle, skew registers cleared, no done; abort beats start and in_valid in the same cycle.
REQ-029 Without SYSTOLIC_FEEDER_ABORT_EN: no abort port; jobs run to completion.

Structure
REQ-030 Package systolic_pkg SHALL hold BITS/DIM defaults and the feeder state enum.
REQ-031 Sub-module skew_lane (parameter DEPTH, BITS; shift register with advance enable and sync clear) SHALL be instantiated per lane, DEPTH=lane index.

Verification (DIM=4, BITS=8)
REQ-032 start, 4 back-to-back transfers A_col=B_row={1,2,3,4} -> mac_en high 10 consecutive cycles, done 1 cycle after, A_out[3] first nonzero 3 cycles after A_out[0].
REQ-033 Same job with in_valid low 2 cycles after step 1 -> mac_en low those 2 cycles, A_out/B_out zero, skew contents unchanged, done 12 cycles after first transfer.
REQ-034 Array + feeder, A=B=identity -> Cout identity at done.
REQ-035 Array + feeder, A all 127, B all -128 -> every Cout = -65024 at done.
REQ-036 rst_n low during FLUSH cycle 3 -> all outputs 0 immediately, no done; next start runs a clean job.
REQ-037 With SYSTOLIC_FEEDER_ABORT_EN, abort with in_valid in LOAD step 2 -> IDLE next cycle, busy=0, no done; start raised during LOAD/FLUSH has no effect.
